// File: rtl/riscv_to_mips_translator.sv
// riscv_to_mips_translator: streaming RV32I -> MIPS32 translator.
// Each accepted RISC-V word is decoded into a 1-3 word MIPS group that is
// buffered and then emitted one word per cycle on a valid/ready stream.
module riscv_to_mips_translator (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rv_valid,
    output logic        rv_ready,
    input  logic [31:0] rv_instr,
    output logic        mips_valid,
    input  logic        mips_ready,
    output logic [31:0] mips_instr,
    output logic        mips_last,
    output logic        mips_illegal
);
    localparam logic [4:0] TMP_REG = 5'd26;

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] funct);
        return {6'b000000, rs, rt, rd, 5'b00000, funct};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    logic [6:0]  opc;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [15:0] imm_i, imm_s, br_off;
    assign opc   = rv_instr[6:0];
    assign rd    = rv_instr[11:7];
    assign f3    = rv_instr[14:12];
    assign rs1   = rv_instr[19:15];
    assign rs2   = rv_instr[24:20];
    assign f7    = rv_instr[31:25];
    assign imm_i = {{4{rv_instr[31]}}, rv_instr[31:20]};
    assign imm_s = {{4{rv_instr[31]}}, rv_instr[31:25], rv_instr[11:7]};
    // word offset = sext16(imm[12:2]); imm[12]=instr[31], imm[11]=instr[7]
    assign br_off = {{5{rv_instr[31]}}, rv_instr[31], rv_instr[7], rv_instr[30:25], rv_instr[11:9]};

    logic [2:0][31:0] dec_w;
    logic [1:0]       dec_cnt;
    logic             dec_ill;

    // Decode the incoming RISC-V word into a complete MIPS group
    always_comb begin
        dec_w   = '0;
        dec_cnt = 2'd1;
        dec_ill = 1'b0;
        case (opc)
            7'b0110011: begin
                if (f7 == 7'b0000000) begin
                    case (f3)
                        3'b000: dec_w[0] = rtype(rs1, rs2, rd, 6'h21);
                        3'b001: dec_w[0] = rtype(rs2, rs1, rd, 6'h04);
                        3'b010: dec_w[0] = rtype(rs1, rs2, rd, 6'h2A);
                        3'b011: dec_w[0] = rtype(rs1, rs2, rd, 6'h2B);
                        3'b100: dec_w[0] = rtype(rs1, rs2, rd, 6'h26);
                        3'b101: dec_w[0] = rtype(rs2, rs1, rd, 6'h06);
                        3'b110: dec_w[0] = rtype(rs1, rs2, rd, 6'h25);
                        default: dec_w[0] = rtype(rs1, rs2, rd, 6'h24);
                    endcase
                end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
                    dec_w[0] = rtype(rs1, rs2, rd, 6'h23);
                end else if (f7 == 7'b0100000 && f3 == 3'b101) begin
                    dec_w[0] = rtype(rs2, rs1, rd, 6'h07);
                end else begin
                    dec_ill = 1'b1;
                end
            end
            7'b0010011: begin
                case (f3)
                    3'b000: dec_w[0] = itype(6'b001001, rs1, rd, imm_i);
                    3'b010: dec_w[0] = itype(6'b001010, rs1, rd, imm_i);
                    3'b011: dec_w[0] = itype(6'b001011, rs1, rd, imm_i);
                    3'b100, 3'b110, 3'b111: begin
                        if (rv_instr[31]) begin
                            // negative logical immediate: materialise in $k0 first
                            dec_w[0] = itype(6'b001001, 5'd0, TMP_REG, imm_i);
                            dec_w[1] = rtype(rs1, TMP_REG, rd, (f3 == 3'b100) ? 6'h26 :
                                                               (f3 == 3'b110) ? 6'h25 : 6'h24);
                            dec_cnt  = 2'd2;
                        end else begin
                            dec_w[0] = itype((f3 == 3'b100) ? 6'b001110 :
                                             (f3 == 3'b110) ? 6'b001101 : 6'b001100,
                                             rs1, rd, {4'h0, rv_instr[31:20]});
                        end
                    end
                    3'b001: begin
                        if (f7 == 7'b0000000) dec_w[0] = {11'b0, rs1, rd, rs2, 6'h00};
                        else dec_ill = 1'b1;
                    end
                    default: begin
                        if (f7 == 7'b0000000)      dec_w[0] = {11'b0, rs1, rd, rs2, 6'h02};
                        else if (f7 == 7'b0100000) dec_w[0] = {11'b0, rs1, rd, rs2, 6'h03};
                        else                       dec_ill = 1'b1;
                    end
                endcase
            end
            7'b0110111: begin
                if (rd != 5'd0) begin
                    dec_w[0] = itype(6'b001111, 5'd0, rd, rv_instr[31:16]);
                    if (rv_instr[15:12] != 4'h0) begin
                        dec_w[1] = itype(6'b001101, rd, rd, {rv_instr[15:12], 12'h000});
                        dec_cnt  = 2'd2;
                    end
                end
            end
            7'b0000011: begin
                case (f3)
                    3'b000: dec_w[0] = itype(6'h20, rs1, rd, imm_i);
                    3'b001: dec_w[0] = itype(6'h21, rs1, rd, imm_i);
                    3'b010: dec_w[0] = itype(6'h23, rs1, rd, imm_i);
                    3'b100: dec_w[0] = itype(6'h24, rs1, rd, imm_i);
                    3'b101: dec_w[0] = itype(6'h25, rs1, rd, imm_i);
                    default: dec_ill = 1'b1;
                endcase
            end
            7'b0100011: begin
                case (f3)
                    3'b000: dec_w[0] = itype(6'h28, rs1, rs2, imm_s);
                    3'b001: dec_w[0] = itype(6'h29, rs1, rs2, imm_s);
                    3'b010: dec_w[0] = itype(6'h2B, rs1, rs2, imm_s);
                    default: dec_ill = 1'b1;
                endcase
            end
            7'b1100011: begin
                // offsets are relative to the branch word; the downstream pass rebases
                if (rv_instr[8] || f3 == 3'b010 || f3 == 3'b011) begin
                    dec_ill = 1'b1;
                end else if (f3[2] == 1'b0) begin
                    dec_w[0] = itype(f3[0] ? 6'b000101 : 6'b000100, rs1, rs2, br_off - 16'd1);
                    dec_cnt  = 2'd2;
                end else begin
                    dec_w[0] = rtype(rs1, rs2, TMP_REG, f3[1] ? 6'h2B : 6'h2A);
                    dec_w[1] = itype(f3[0] ? 6'b000100 : 6'b000101, TMP_REG, 5'd0, br_off - 16'd2);
                    dec_cnt  = 2'd3;
                end
            end
            7'b1110011: begin
                if (rv_instr == 32'h0000_0073)      dec_w[0] = 32'h0000_000C;
                else if (rv_instr == 32'h0010_0073) dec_w[0] = 32'h0000_000D;
                else                                dec_ill = 1'b1;
            end
            default: dec_ill = 1'b1;
        endcase
        if (dec_ill) begin
            dec_w   = '0;
            dec_cnt = 2'd1;
        end
    end

    logic [2:0][31:0] buf_q, buf_d;
    logic [1:0]       cnt_q, cnt_d, idx_q, idx_d;
    logic             vld_q, vld_d, ill_q, ill_d;
    logic             last, in_fire, out_fire;

    assign last         = vld_q && (idx_q == cnt_q - 2'd1);
    assign rv_ready     = !vld_q || (mips_ready && last);
    assign in_fire      = rv_valid && rv_ready;
    assign out_fire     = vld_q && mips_ready;
    assign mips_valid   = vld_q;
    assign mips_last    = last;
    assign mips_illegal = ill_q;

    // Select the current word of the buffered group
    always_comb begin
        case (idx_q)
            2'd0:    mips_instr = buf_q[0];
            2'd1:    mips_instr = buf_q[1];
            default: mips_instr = buf_q[2];
        endcase
    end

    // Group sequencing: load on accept, step index on output handshake
    always_comb begin
        buf_d = buf_q;
        cnt_d = cnt_q;
        idx_d = idx_q;
        vld_d = vld_q;
        ill_d = ill_q;
        if (in_fire) begin
            buf_d = dec_w;
            cnt_d = dec_cnt;
            idx_d = 2'd0;
            vld_d = 1'b1;
            ill_d = dec_ill;
        end else if (out_fire) begin
            if (last) vld_d = 1'b0;
            else      idx_d = idx_q + 2'd1;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            buf_q <= '0;
            cnt_q <= 2'd0;
            idx_q <= 2'd0;
            vld_q <= 1'b0;
            ill_q <= 1'b0;
        end else begin
            buf_q <= buf_d;
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            vld_q <= vld_d;
            ill_q <= ill_d;
        end
    end
endmodule

// File: tb/tb_riscv_to_mips_translator.sv
// Directed self-checking bench for riscv_to_mips_translator.
module tb_riscv_to_mips_translator;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        rv_valid;
    logic        rv_ready;
    logic [31:0] rv_instr;
    logic        mips_valid;
    logic        mips_ready;
    logic [31:0] mips_instr;
    logic        mips_last;
    logic        mips_illegal;

    int checks = 0;
    int errors = 0;

    riscv_to_mips_translator dut (
        .clk(clk), .rst_n(rst_n),
        .rv_valid(rv_valid), .rv_ready(rv_ready), .rv_instr(rv_instr),
        .mips_valid(mips_valid), .mips_ready(mips_ready), .mips_instr(mips_instr),
        .mips_last(mips_last), .mips_illegal(mips_illegal)
    );

    always #5 clk = ~clk;

    // advance one clock; inputs change and outputs are sampled 1ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // present one RISC-V word for exactly one cycle (block is expected ready)
    task automatic send(input logic [31:0] ins);
        rv_valid = 1'b1;
        rv_instr = ins;
        step();
        rv_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rv_valid = 1'b0; rv_instr = '0; mips_ready = 1'b1;
        step(); step();
        checks++;
        if ({mips_valid, mips_last, mips_illegal} !== 3'b000 || mips_instr !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b l=%b i=%b w=%h, want 0 0 0 00000000",
                     mips_valid, mips_last, mips_illegal, mips_instr);
        end
        rst_n = 1'b1;
        step();
        checks++;
        if (rv_ready !== 1'b1) begin
            errors++; $display("FAIL reset_rv_ready: got %b want 1", rv_ready);
        end
    endtask

    // single-word translations: one word, last=1, gone next cycle
    task automatic test_single();
        logic [31:0] vin  [9] = '{32'h002081B3, 32'h407302B3, 32'h007312B3, 32'h40335293,
                                  32'h12336293, 32'hFFC32283, 32'h00732423, 32'h00100073,
                                  32'h12340537};
        logic [31:0] vexp [9] = '{32'h00221821, 32'h00C72823, 32'h00E62804, 32'h000628C3,
                                  32'h34C50123, 32'h8CC5FFFC, 32'hACC70008, 32'h0000000D,
                                  32'h3C0A1234};
        for (int i = 0; i < 9; i++) begin
            send(vin[i]);
            checks++;
            if (mips_valid !== 1'b1 || mips_instr !== vexp[i] || mips_last !== 1'b1 || mips_illegal !== 1'b0) begin
                errors++;
                $display("FAIL single_%0d: in=%h got v=%b w=%h l=%b i=%b, want 1 %h 1 0",
                         i, vin[i], mips_valid, mips_instr, mips_last, mips_illegal, vexp[i]);
            end
            step();
            checks++;
            if (mips_valid !== 1'b0) begin
                errors++; $display("FAIL single_done_%0d: valid got %b want 0", i, mips_valid);
            end
        end
    endtask

    // two-word expansions: ANDI negative imm, LUI with low nibble, BEQ
    task automatic test_expand2();
        logic [31:0] vin [3] = '{32'hFFF37293, 32'h12345537, 32'h00208463};
        logic [31:0] w0  [3] = '{32'h241AFFFF, 32'h3C0A1234, 32'h10220001};
        logic [31:0] w1  [3] = '{32'h00DA2824, 32'h354A5000, 32'h00000000};
        for (int i = 0; i < 3; i++) begin
            send(vin[i]);
            checks++;
            if (mips_valid !== 1'b1 || mips_instr !== w0[i] || mips_last !== 1'b0) begin
                errors++;
                $display("FAIL expand2_w0_%0d: got v=%b w=%h l=%b, want 1 %h 0",
                         i, mips_valid, mips_instr, mips_last, w0[i]);
            end
            step();
            checks++;
            if (mips_valid !== 1'b1 || mips_instr !== w1[i] || mips_last !== 1'b1) begin
                errors++;
                $display("FAIL expand2_w1_%0d: got v=%b w=%h l=%b, want 1 %h 1",
                         i, mips_valid, mips_instr, mips_last, w1[i]);
            end
            step();
        end
    endtask

    // BLT with 3 stall cycles, then ecall streamed on the NOP handshake
    task automatic test_back_to_back();
        mips_ready = 1'b0;
        send(32'h0020C863);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (mips_valid !== 1'b1 || mips_instr !== 32'h0022D02A || mips_last !== 1'b0 || rv_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_%0d: got v=%b w=%h l=%b rdy=%b, want 1 0022d02a 0 0",
                         i, mips_valid, mips_instr, mips_last, rv_ready);
            end
            step();
        end
        mips_ready = 1'b1;
        #0;
        checks++;
        if (mips_instr !== 32'h0022D02A) begin
            errors++; $display("FAIL blt_w0: got %h want 0022d02a", mips_instr);
        end
        step();
        checks++;
        if (mips_instr !== 32'h17400002 || mips_last !== 1'b0) begin
            errors++; $display("FAIL blt_w1: got w=%h l=%b want 17400002 0", mips_instr, mips_last);
        end
        step();
        rv_valid = 1'b1;
        rv_instr = 32'h00000073;
        #0;
        checks++;
        if (mips_instr !== 32'h0 || mips_last !== 1'b1 || rv_ready !== 1'b1) begin
            errors++;
            $display("FAIL blt_w2: got w=%h l=%b rdy=%b want 00000000 1 1", mips_instr, mips_last, rv_ready);
        end
        step();
        rv_valid = 1'b0;
        checks++;
        if (mips_valid !== 1'b1 || mips_instr !== 32'h0000000C || mips_last !== 1'b1) begin
            errors++;
            $display("FAIL ecall_b2b: got v=%b w=%h l=%b want 1 0000000c 1", mips_valid, mips_instr, mips_last);
        end
        step();
    endtask

    task automatic test_illegal();
        logic [31:0] vin [2] = '{32'h0000006F, 32'h00208163};
        for (int i = 0; i < 2; i++) begin
            send(vin[i]);
            checks++;
            if (mips_valid !== 1'b1 || mips_instr !== 32'h0 || mips_last !== 1'b1 || mips_illegal !== 1'b1) begin
                errors++;
                $display("FAIL illegal_%0d: got v=%b w=%h l=%b i=%b want 1 00000000 1 1",
                         i, mips_valid, mips_instr, mips_last, mips_illegal);
            end
            step();
        end
    endtask

    task automatic test_mid_reset();
        send(32'hFFF37293);
        checks++;
        if (mips_instr !== 32'h241AFFFF) begin
            errors++; $display("FAIL midrst_w0: got %h want 241affff", mips_instr);
        end
        rst_n = 1'b0;
        step();
        checks++;
        if (mips_valid !== 1'b0 || mips_instr !== 32'h0 || mips_last !== 1'b0) begin
            errors++;
            $display("FAIL midrst_clear: got v=%b w=%h l=%b want 0 00000000 0", mips_valid, mips_instr, mips_last);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (mips_valid !== 1'b0) begin
                errors++; $display("FAIL midrst_no_w1_%0d: valid got %b want 0", i, mips_valid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_expand2();
        test_back_to_back();
        test_illegal();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
